// File: rtl/vlc_pkg.sv
// Shared types and constants for the VLC lamp-sequence monitor.
// Frame classes, decoded modes, fault causes and the legal step table.
package vlc_pkg;

  typedef enum logic [1:0] {
    ModeIdle   = 2'd0,
    ModeLeft   = 2'd1,
    ModeRight  = 2'd2,
    ModeHazard = 2'd3
  } mode_e;

  localparam logic [1:0] FaultNone         = 2'd0;
  localparam logic [1:0] FaultIllegalFrame = 2'd1;
  localparam logic [1:0] FaultIllegalStep  = 2'd2;
  localparam logic [1:0] FaultStuck        = 2'd3;

  typedef enum logic [3:0] {
    FcOff,
    FcL1,
    FcL2,
    FcL3,
    FcR1,
    FcR2,
    FcR3,
    FcHz,
    FcBad
  } frame_class_e;

  // Per-side lamp patterns, filling from the innermost lamp outward.
  localparam logic [2:0] LampOff   = 3'b000;
  localparam logic [2:0] LampStep1 = 3'b001;
  localparam logic [2:0] LampStep2 = 3'b011;
  localparam logic [2:0] LampStep3 = 3'b111;

  function automatic logic step_legal(frame_class_e from_c, frame_class_e to_c);
    logic ok;
    ok = 1'b0;
    case (from_c)
      FcOff:   ok = (to_c == FcL1) || (to_c == FcR1) || (to_c == FcHz);
      FcL1:    ok = (to_c == FcL2);
      FcL2:    ok = (to_c == FcL3);
      FcL3:    ok = (to_c == FcOff);
      FcR1:    ok = (to_c == FcR2);
      FcR2:    ok = (to_c == FcR3);
      FcR3:    ok = (to_c == FcOff);
      FcHz:    ok = (to_c == FcOff);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lamp_frame_classifier.sv
// Combinational map from a 6-bit {left, right} lamp frame to its frame class.
module lamp_frame_classifier
  import vlc_pkg::*;
(
  input  logic [5:0]   frame,
  output frame_class_e frame_class
);

  always_comb begin
    frame_class = FcBad;
    case (frame)
      {LampOff,   LampOff  }: frame_class = FcOff;
      {LampStep1, LampOff  }: frame_class = FcL1;
      {LampStep2, LampOff  }: frame_class = FcL2;
      {LampStep3, LampOff  }: frame_class = FcL3;
      {LampOff,   LampStep1}: frame_class = FcR1;
      {LampOff,   LampStep2}: frame_class = FcR2;
      {LampOff,   LampStep3}: frame_class = FcR3;
      {LampStep3, LampStep3}: frame_class = FcHz;
      default:                frame_class = FcBad;
    endcase
  end

endmodule

// File: rtl/vlc_lamp_monitor.sv
// Watches left/right lamp drives, decodes completed indicator sequences into a mode
// and raises a sticky fault on illegal frames, illegal steps or a stuck non-OFF frame.
module vlc_lamp_monitor
  import vlc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] left_lamp,
  input  logic [2:0] right_lamp,
  input  logic       clear,
  output logic [1:0] mode,
  output logic       mode_valid,
  output logic       seq_done,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntHit = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEFT,
    S_RIGHT,
    S_HAZ,
    S_FAULT
  } state_e;

  logic [5:0]      frame_q, frame_p;
  logic [CntW-1:0] count_q;
  state_e          state_q;
  mode_e           mode_q;
  frame_class_e    cls_q, cls_p;

  logic       changed, bad_frame, bad_step, timeout_hit, stuck, idle_hit;
  logic [1:0] cause;

  lamp_frame_classifier u_cls_q (
    .frame       (frame_q),
    .frame_class (cls_q)
  );

  lamp_frame_classifier u_cls_p (
    .frame       (frame_p),
    .frame_class (cls_p)
  );

  always_comb begin
    changed     = (frame_q != frame_p);
    bad_frame   = (cls_q == FcBad);
    // A step out of an illegal frame (only possible right after clear) is not judged.
    bad_step    = changed && (cls_p != FcBad) && !step_legal(cls_p, cls_q);
    timeout_hit = !changed && (count_q == CntHit);
    stuck       = timeout_hit && (cls_q != FcOff);
    idle_hit    = timeout_hit && (cls_q == FcOff);
    cause       = FaultNone;
    if (bad_frame)     cause = FaultIllegalFrame;
    else if (bad_step) cause = FaultIllegalStep;
    else if (stuck)    cause = FaultStuck;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      frame_p    <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      mode_q     <= ModeIdle;
      mode_valid <= 1'b0;
      seq_done   <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FaultNone;
    end else begin
      frame_q  <= {left_lamp, right_lamp};
      frame_p  <= frame_q;
      seq_done <= 1'b0;

      if (clear || changed) begin
        count_q <= '0;
      end else if (count_q != CntMax) begin
        count_q <= count_q + CntW'(1);
      end

      if (clear) begin
        state_q    <= S_IDLE;
        mode_q     <= ModeIdle;
        mode_valid <= 1'b0;
        fault      <= 1'b0;
        fault_code <= FaultNone;
      end else if (state_q != S_FAULT) begin
        if (cause != FaultNone) begin
          state_q    <= S_FAULT;
          fault      <= 1'b1;
          fault_code <= cause;
          mode_valid <= 1'b0;
        end else if (idle_hit) begin
          mode_q     <= ModeIdle;
          mode_valid <= 1'b1;
        end else if (changed) begin
          // Legal steps only reach OFF from L3/R3/HZ, so OFF here ends a full sequence.
          case (state_q)
            S_IDLE: begin
              if (cls_q == FcL1)      state_q <= S_LEFT;
              else if (cls_q == FcR1) state_q <= S_RIGHT;
              else if (cls_q == FcHz) state_q <= S_HAZ;
            end
            S_LEFT: begin
              if (cls_q == FcOff) begin
                state_q    <= S_IDLE;
                seq_done   <= 1'b1;
                mode_q     <= ModeLeft;
                mode_valid <= 1'b1;
              end
            end
            S_RIGHT: begin
              if (cls_q == FcOff) begin
                state_q    <= S_IDLE;
                seq_done   <= 1'b1;
                mode_q     <= ModeRight;
                mode_valid <= 1'b1;
              end
            end
            S_HAZ: begin
              if (cls_q == FcOff) begin
                state_q    <= S_IDLE;
                seq_done   <= 1'b1;
                mode_q     <= ModeHazard;
                mode_valid <= 1'b1;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_vlc_lamp_monitor.sv
// Self-checking bench for vlc_lamp_monitor with TIMEOUT_CYCLES = 16.
module tb_vlc_lamp_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] left_lamp = 3'b000;
  logic [2:0] right_lamp = 3'b000;
  logic       clear = 1'b0;
  logic [1:0] mode;
  logic       mode_valid;
  logic       seq_done;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  vlc_lamp_monitor #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .left_lamp  (left_lamp),
    .right_lamp (right_lamp),
    .clear      (clear),
    .mode       (mode),
    .mode_valid (mode_valid),
    .seq_done   (seq_done),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  // Every seq_done pulse must match the next expected completion.
  always @(negedge clk) begin
    logic [1:0] m;
    if (rst_n && seq_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL seq_done_unexpected: got pulse with mode=%0d, required no pulse", mode);
      end else begin
        m = exp_q.pop_front();
        if (mode !== m || mode_valid !== 1'b1) begin
          errors++;
          $display("FAIL seq_done_mode: got mode=%0d valid=%0b, required mode=%0d valid=1",
                   mode, mode_valid, m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input logic [2:0] l, input logic [2:0] r, input int n);
    left_lamp = l;
    right_lamp = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d missing seq_done pulses, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({mode, mode_valid, seq_done, fault, fault_code} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {mode, mode_valid, seq_done, fault, fault_code});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({mode, mode_valid, seq_done, fault, fault_code} !== 7'd0) begin
      errors++;
      $display("FAIL reset_release: got %b, required 0000000",
               {mode, mode_valid, seq_done, fault, fault_code});
    end
  endtask

  task automatic test_left();
    hold(3'b000, 3'b000, 4);
    hold(3'b001, 3'b000, 4);
    hold(3'b011, 3'b000, 4);
    hold(3'b111, 3'b000, 4);
    exp_q.push_back(2'd1);
    hold(3'b000, 3'b000, 4);
    checks++;
    if (mode !== 2'd1 || mode_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL left_mode: got mode=%0d valid=%0b fault=%0b, required 1 1 0",
               mode, mode_valid, fault);
    end
    check_drained("left");
  endtask

  task automatic test_hazard();
    hold(3'b111, 3'b111, 4);
    exp_q.push_back(2'd3);
    hold(3'b000, 3'b000, 4);
    checks++;
    if (mode !== 2'd3 || mode_valid !== 1'b1) begin
      errors++;
      $display("FAIL hazard_mode: got mode=%0d valid=%0b, required 3 1", mode, mode_valid);
    end
    hold(3'b000, 3'b000, 16);
    checks++;
    if (mode !== 2'd0 || mode_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: got mode=%0d valid=%0b fault=%0b, required 0 1 0",
               mode, mode_valid, fault);
    end
    check_drained("hazard");
  endtask

  task automatic test_bad_frame();
    hold(3'b010, 3'b000, 1);
    hold(3'b000, 3'b000, 3);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || mode_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_frame: got fault=%0b code=%0d valid=%0b, required 1 1 0",
               fault, fault_code, mode_valid);
    end
    hold(3'b001, 3'b000, 4);
    hold(3'b011, 3'b000, 4);
    hold(3'b111, 3'b000, 4);
    hold(3'b000, 3'b000, 4);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || mode_valid !== 1'b0) begin
      errors++;
      $display("FAIL fault_sticky: got fault=%0b code=%0d valid=%0b, required 1 1 0",
               fault, fault_code, mode_valid);
    end
    pulse_clear();
    checks++;
    if ({mode, mode_valid, seq_done, fault, fault_code} !== 7'd0) begin
      errors++;
      $display("FAIL clear_outputs: got %b, required 0000000",
               {mode, mode_valid, seq_done, fault, fault_code});
    end
  endtask

  task automatic test_skip();
    hold(3'b000, 3'b000, 4);
    hold(3'b001, 3'b000, 4);
    hold(3'b111, 3'b000, 4);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2) begin
      errors++;
      $display("FAIL skip_step: got fault=%0b code=%0d, required 1 2", fault, fault_code);
    end
    pulse_clear();
    hold(3'b000, 3'b000, 4);
    hold(3'b001, 3'b000, 4);
    left_lamp = 3'b111;
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'd0 || mode_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: got fault=%0b code=%0d valid=%0b, required 0 0 0",
               fault, fault_code, mode_valid);
    end
    hold(3'b111, 3'b000, 6);
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_late_fault: got fault=%0b, required 0", fault);
    end
    hold(3'b000, 3'b000, 4);
    hold(3'b000, 3'b001, 4);
    hold(3'b000, 3'b011, 4);
    hold(3'b000, 3'b111, 4);
    exp_q.push_back(2'd2);
    hold(3'b000, 3'b000, 4);
    checks++;
    if (mode !== 2'd2 || mode_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL after_clear_seq: got mode=%0d valid=%0b fault=%0b, required 2 1 0",
               mode, mode_valid, fault);
    end
    check_drained("skip");
  endtask

  task automatic test_stuck_and_reset();
    int n;
    hold(3'b000, 3'b000, 4);
    hold(3'b000, 3'b001, 4);
    right_lamp = 3'b011;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (fault === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 18 || fault_code !== 2'd3 || mode_valid !== 1'b0) begin
      errors++;
      $display("FAIL stuck_timeout: got edges=%0d code=%0d valid=%0b, required 18 3 0",
               n, fault_code, mode_valid);
    end
    hold(3'b000, 3'b000, 4);
    pulse_clear();
    hold(3'b000, 3'b001, 4);
    hold(3'b000, 3'b011, 4);
    hold(3'b000, 3'b111, 4);
    exp_q.push_back(2'd2);
    hold(3'b000, 3'b000, 4);
    check_drained("stuck");
    hold(3'b000, 3'b001, 4);
    right_lamp = 3'b011;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mode, mode_valid, seq_done, fault, fault_code} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got %b, required 0000000",
               {mode, mode_valid, seq_done, fault, fault_code});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2) begin
      errors++;
      $display("FAIL first_frame_vs_off: got fault=%0b code=%0d, required 1 2",
               fault, fault_code);
    end
    hold(3'b000, 3'b000, 4);
    pulse_clear();
  endtask

  task automatic test_back_to_back();
    hold(3'b001, 3'b000, 2);
    hold(3'b011, 3'b000, 2);
    hold(3'b111, 3'b000, 2);
    exp_q.push_back(2'd1);
    hold(3'b000, 3'b000, 2);
    hold(3'b000, 3'b001, 2);
    hold(3'b000, 3'b011, 2);
    hold(3'b000, 3'b111, 2);
    exp_q.push_back(2'd2);
    hold(3'b000, 3'b000, 2);
    checks++;
    if (mode !== 2'd2 || mode_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_right: got mode=%0d valid=%0b, required 2 1", mode, mode_valid);
    end
    hold(3'b111, 3'b111, 2);
    exp_q.push_back(2'd3);
    hold(3'b000, 3'b000, 3);
    checks++;
    if (mode !== 2'd3 || mode_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hazard: got mode=%0d valid=%0b fault=%0b, required 3 1 0",
               mode, mode_valid, fault);
    end
    check_drained("b2b");
  endtask

  initial begin
    test_reset();
    test_left();
    test_hazard();
    test_bad_frame();
    test_skip();
    test_stuck_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
